// File: rtl/pt2262_tx_scheduler.sv
// pt2262_tx_scheduler: round-robin scheduler sharing one PT2262 encoder among NREQ requesters.
// Revision 1.0
`default_nettype none

module pt2262_tx_scheduler #(
    parameter int NREQ    = 4,
    parameter int REPEATS = 4,
    parameter int RST_CYC = 4,
    parameter int TIMEOUT = 200000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_d,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     ack,
    output logic                err,
    output logic                busy,
    output logic [7:0]          enc_a,
    output logic [3:0]          enc_d,
    output logic                enc_rst,
    input  logic                enc_sync,
    output logic [3:0]          frame_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_HOLD = 2'd1;
    localparam logic [1:0]    S_SEND = 2'd2;
    localparam logic [1:0]    S_DONE = 2'd3;

    localparam logic [7:0]    HOLD_LAST = 8'(RST_CYC - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [3:0]    REP       = 4'(REPEATS);
    localparam logic [PW:0]   NREQ_W    = (PW+1)'(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [7:0]      enc_a_q, enc_a_d;
    logic [3:0]      enc_d_q, enc_d_d;
    logic            enc_rst_q, enc_rst_d;
    logic [3:0]      fcnt_q, fcnt_d;
    logic [7:0]      hold_q, hold_d;
    logic [TW-1:0]   to_q, to_d;
    logic [2:0]      sync_q;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW:0]     cand;
    logic [7:0]      win_a;
    logic [3:0]      win_dd;
    logic [PW:0]     nxt_ptr;
    logic            frame_end;

    // Falling edge of the synchronized sync marks the end of a frame.
    assign frame_end = sync_q[2] & ~sync_q[1];

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!win_found && req[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        win_a  = '0;
        win_dd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) begin
                win_a  = req_a[8*i +: 8];
                win_dd = req_d[4*i +: 4];
            end
        end
    end

    always_comb begin
        nxt_ptr = {1'b0, gidx_q} + (PW+1)'(1);
        if (nxt_ptr == NREQ_W) begin
            nxt_ptr = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        err_d     = 1'b0;
        busy_d    = busy_q;
        enc_a_d   = enc_a_q;
        enc_d_d   = enc_d_q;
        enc_rst_d = enc_rst_q;
        fcnt_d    = fcnt_q;
        hold_d    = hold_q;
        to_d      = to_q;

        case (state_q)
            S_IDLE: begin
                enc_rst_d = 1'b1;
                busy_d    = 1'b0;
                gnt_d     = '0;
                if (win_found) begin
                    gnt_d   = ONE_HOT0 << win_idx;
                    gidx_d  = win_idx;
                    enc_a_d = win_a;
                    enc_d_d = win_dd;
                    busy_d  = 1'b1;
                    fcnt_d  = '0;
                    hold_d  = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d   = S_SEND;
                    enc_rst_d = 1'b0;
                    to_d      = '0;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            S_SEND: begin
                to_d = to_q + TW'(1);
                if (frame_end) begin
                    fcnt_d = fcnt_q + 4'd1;
                    to_d   = '0;
                end
                // A frame that completes the quota wins over a coincident timeout.
                if (frame_end && (fcnt_q + 4'd1 == REP)) begin
                    state_d   = S_DONE;
                    ack_d     = gnt_q;
                    err_d     = 1'b0;
                    enc_rst_d = 1'b1;
                end else if (to_q == TO_LAST) begin
                    state_d   = S_DONE;
                    ack_d     = gnt_q;
                    err_d     = 1'b1;
                    enc_rst_d = 1'b1;
                end
            end
            default: begin
                ptr_d   = nxt_ptr[PW-1:0];
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            enc_a_q   <= '0;
            enc_d_q   <= '0;
            enc_rst_q <= 1'b1;
            fcnt_q    <= '0;
            hold_q    <= '0;
            to_q      <= '0;
            sync_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            enc_a_q   <= enc_a_d;
            enc_d_q   <= enc_d_d;
            enc_rst_q <= enc_rst_d;
            fcnt_q    <= fcnt_d;
            hold_q    <= hold_d;
            to_q      <= to_d;
            sync_q    <= {sync_q[1:0], enc_sync};
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign enc_a     = enc_a_q;
    assign enc_d     = enc_d_q;
    assign enc_rst   = enc_rst_q;
    assign frame_cnt = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pt2262_tx_scheduler.sv
// tb_pt2262_tx_scheduler: scoreboard bench with a simple frame-generating encoder model.
// Revision 1.0
`default_nettype none

module tb_pt2262_tx_scheduler;

    localparam int NREQ    = 4;
    localparam int REPEATS = 4;
    localparam int RST_CYC = 4;
    localparam int TIMEOUT = 300;
    localparam int FRAME   = 40;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_d;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic              busy;
    logic [7:0]        enc_a;
    logic [3:0]        enc_d;
    logic              enc_rst;
    logic              enc_sync;
    logic [3:0]        frame_cnt;

    pt2262_tx_scheduler #(
        .NREQ(NREQ), .REPEATS(REPEATS), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_d(req_d),
        .gnt(gnt), .ack(ack), .err(err), .busy(busy), .enc_a(enc_a), .enc_d(enc_d),
        .enc_rst(enc_rst), .enc_sync(enc_sync), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Encoder model: sync high for the last 10 cycles of each 40-cycle frame.
    int   mcnt;
    int   sync_mode;
    logic man_sync;
    always @(posedge clk) begin
        if (enc_rst) mcnt <= 0;
        else         mcnt <= mcnt + 1;
    end
    assign enc_sync = (sync_mode == 1) ? 1'b0 :
                      (sync_mode == 2) ? man_sync :
                      (!enc_rst && ((mcnt % FRAME) >= FRAME - 10));

    typedef struct packed {
        logic [1:0] idx;
        logic       err;
        logic [3:0] fc;
        logic [7:0] a;
        logic [3:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [NREQ-1:0] rearm;
    logic [NREQ-1:0] pending;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic e, input int fc);
        exp_t x;
        x.idx = 2'(idx);
        x.err = e;
        x.fc  = 4'(fc);
        x.a   = req_a[8*idx +: 8];
        x.d   = req_d[4*idx +: 4];
        sb.push_back(x);
    endtask

    // Monitor: compare every ack against the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
            if (ack !== '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("ack_owner", 32'(ack), 32'(4'b0001 << x.idx));
                    chk("ack_err", 32'(err), 32'(x.err));
                    chk("ack_frame_cnt", 32'(frame_cnt), 32'(x.fc));
                    chk("ack_enc_a", 32'(enc_a), 32'(x.a));
                    chk("ack_enc_d", 32'(enc_d), 32'(x.d));
                    chk("ack_enc_rst", 32'(enc_rst), 32'd1);
                end
            end
        end
    end

    // Advance one cycle; requesters drop req on ack and optionally rearm a cycle later.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                req[i] = 1'b0;
                if (rearm[i]) begin
                    pending[i] = 1'b1;
                    rearm[i]   = 1'b0;
                end
            end else if (pending[i]) begin
                req[i]     = 1'b1;
                pending[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input string nm, input int limit);
        int n;
        n = 0;
        while (!(req == '0 && !busy) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) chk(nm, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; req = '0; req_a = '0; req_d = '0;
        sync_mode = 0; man_sync = 1'b0; rearm = '0; pending = '0;
        repeat (3) tick();
        chk("rst_enc_rst", 32'(enc_rst), 32'd1);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack_err", 32'({ack, err}), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_enc_ad", 32'({enc_a, enc_d}), 32'd0);
        reset = 1'b0;
        tick();

        // Single requester basic service.
        req_a[7:0] = 8'h5A; req_d[3:0] = 4'hC; req = 4'b0001;
        push(0, 1'b0, 4);
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_enc_a", 32'(enc_a), 32'h5A);
        chk("t1_enc_d", 32'(enc_d), 32'hC);
        chk("t1_busy", 32'(busy), 32'd1);
        repeat (RST_CYC - 1) tick();
        chk("t1_enc_rst_hold", 32'(enc_rst), 32'd1);
        tick();
        chk("t1_enc_rst_fall", 32'(enc_rst), 32'd0);
        wait_done("t1_timeout", 1000);

        reset = 1'b1; tick(); reset = 1'b0; tick();

        // Round robin, requester 0 rearms once.
        req_a = {8'hD4, 8'hC3, 8'h11, 8'hA1};
        req_d = {4'h4, 4'h3, 4'h2, 4'h1};
        rearm = 4'b0001;
        push(0, 1'b0, 4); push(1, 1'b0, 4); push(2, 1'b0, 4); push(3, 1'b0, 4); push(0, 1'b0, 4);
        req = 4'b1111;
        wait_done("t2_timeout", 3000);

        // Address change during SEND is ignored.
        req = 4'b0010;
        push(1, 1'b0, 4);
        tick();
        chk("t5_gnt", 32'(gnt), 32'h2);
        repeat (RST_CYC + 10) tick();
        req_a[15:8] = 8'hFF;
        tick();
        chk("t5_enc_a_held", 32'(enc_a), 32'h11);
        wait_done("t5_timeout", 1000);
        req_a[15:8] = 8'h11;

        // Timeout with sync stuck low.
        sync_mode = 1;
        req = 4'b0100;
        push(2, 1'b1, 0);
        tick();
        chk("t3_gnt", 32'(gnt), 32'h4);
        n = 0;
        while (ack == '0 && n < 1000) begin
            tick();
            n++;
        end
        chk("t3_latency_ok", 32'(n >= RST_CYC + TIMEOUT - 1 && n <= RST_CYC + TIMEOUT + 1), 32'd1);
        wait_done("t3_timeout", 100);
        sync_mode = 0;

        // Sync pulse during RST_HOLD is not counted.
        sync_mode = 2; man_sync = 1'b1;
        req = 4'b0001;
        push(0, 1'b0, 4);
        tick();
        chk("t6_gnt", 32'(gnt), 32'h1);
        man_sync = 1'b0; sync_mode = 0;
        repeat (RST_CYC) tick();
        chk("t6_send_entry", 32'(enc_rst), 32'd0);
        chk("t6_frame_cnt0", 32'(frame_cnt), 32'd0);
        wait_done("t6_timeout", 1000);

        // Reset mid-service, then pointer restarts at 0.
        req = 4'b0001;
        n = 0;
        while (frame_cnt != 4'd2 && n < 500) begin
            tick();
            n++;
        end
        chk("t4_two_frames", 32'(frame_cnt), 32'd2);
        reset = 1'b1;
        tick();
        chk("t4_enc_rst", 32'(enc_rst), 32'd1);
        chk("t4_gnt", 32'(gnt), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("t4_no_ack", 32'(ack), 32'd0);
        reset = 1'b0;
        req = 4'b1001;
        push(0, 1'b0, 4); push(3, 1'b0, 4);
        tick();
        chk("t4_regrant", 32'(gnt), 32'h1);
        wait_done("t4_timeout", 2000);

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/pt2262_tx_scheduler.md
Name: pt2262_tx_scheduler

Overview:
- Shares one codificador_pt2262 encoder between NREQ requesters. Each requester supplies an 8-bit trinary address and a 4-bit data word.
- Grants requesters round-robin and latches the winner's A/D into the encoder.
- Controls the encoder's reset to start transmission, then counts completed frames via the encoder's sync output.
- Parks the encoder in reset after REPEATS frames (or on timeout) and acknowledges the requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- REPEATS, 4, frames sent per grant (1..15).
- RST_CYC, 4, clk cycles enc_rst is held high before each transmission (1..255).
- TIMEOUT, 200000, max clk cycles between frame ends before abort (one frame ≈ 128k clk at 3MHz).

Ports:
- clk  in  1  system clock, 3MHz, same clock as encoder clk.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester transmit request, level, held until ack.
- req_a  in  8*NREQ  address of requester i in bits [8i+7:8i].
- req_d  in  4*NREQ  data of requester i in bits [4i+3:4i].
- gnt  out  NREQ  one-hot, current owner of encoder; 0 when idle.
- ack  out  NREQ  one-cycle pulse to the owner at end of service.
- err  out  1  valid with ack; 1 = serviced by timeout abort.
- busy  out  1  high from grant through the DONE cycle.
- enc_a  out  8  drives encoder A.
- enc_d  out  4  drives encoder D.
- enc_rst  out  1  drives encoder reset; high = encoder held idle.
- enc_sync  in  1  encoder sync output (asynchronous to clk, osc domain).
- frame_cnt  out  4  frames completed in current grant.

Behaviour:
- Reset values: enc_rst=1, enc_a=0, enc_d=0, gnt=0, ack=0, err=0, busy=0, frame_cnt=0, rr pointer=0, state=IDLE, synchronizer flops=0. All state registers use synchronous reset; reset mid-operation aborts immediately with no ack, and enc_rst=1 after that edge.
- enc_sync passes through a 2-flop synchronizer plus a third history flop. frame_end = s3 & ~s2, i.e. falling edge of sync = end of the frame's SYNC bit.
- Arbitration: round-robin starting at index ptr. Search order is ptr, ptr+1, ..., wrapping at NREQ. In DONE, ptr <= granted index + 1 (mod NREQ).
- States:
  - IDLE: enc_rst=1, busy=0.
    - If req≠0 at edge k, then after edge k: gnt=onehot(winner), enc_a/enc_d latch the winner's slices, busy=1, frame_cnt=0, hold counter=0, state=RST_HOLD.
  - RST_HOLD: enc_rst=1; counter increments each cycle.
    - After RST_CYC cycles in RST_HOLD, go to SEND with enc_rst=0 and timeout counter=0.
    - frame_end in this state is ignored.
  - SEND: enc_rst=0; timeout counter increments each cycle.
    - On frame_end: frame_cnt++ and timeout counter clears.
    - When frame_cnt reaches REPEATS: go to DONE with err=0.
    - If the timeout counter reaches TIMEOUT-1 with no frame_end: go to DONE with err=1.
    - If frame_end and timeout coincide, the frame is counted; err=1 only if REPEATS has not been reached.
  - DONE (1 cycle): ack=gnt, err valid, enc_rst=1, ptr updated. Next edge: gnt=0, ack=0, err=0, busy=0, state=IDLE.
- The requester must drop req on the cycle after ack. If req is still high it is re-arbitrated in IDLE against the others, and others win first.
- enc_a/enc_d are held constant from grant until the next grant. Changes on req_a/req_d during service are ignored.
- Deasserting req mid-service does not abort; service completes and ack still pulses.
- Minimum IDLE dwell between grants: 1 cycle.
- frame_cnt holds its value through DONE and clears at the next grant.

Test Plan:
- Only req[0]=1, req_a[7:0]=8'h5A, req_d[3:0]=4'hC, behavioural encoder model → gnt=0001, enc_a=5A, enc_d=C the cycle after req. enc_rst falls 4 cycles later. After the 4th sync falling edge (+3 sync flops), ack[0] pulses one cycle, err=0, frame_cnt=4, enc_rst=1.
- req=1111 held, each requester drops req after its ack and reasserts 1 cycle later → grant sequence 0,1,2,3,0. Each gnt is one-hot and lasts until its ack.
- enc_sync tied 0 with req[2]=1 → ack[2] with err=1 exactly RST_CYC+TIMEOUT cycles (±1 for state entry) after gnt. frame_cnt=0.
- reset asserted after 2 frame_ends → after that edge: enc_rst=1, gnt=0, busy=0, frame_cnt=0, no ack. A new request on req[3] with req[0] also high → req[0] wins (ptr=0).
- req_a[15:8] changed from 8'h11 to 8'hFF during SEND for owner 1 → enc_a stays 8'h11 until DONE.
- sync pulse injected during RST_HOLD → not counted. frame_cnt stays 0 at SEND entry; service still needs 4 frame_ends.
